pythagoras_leg: RTL and testbench



---
 rtl/pythagoras_pkg.sv | 17 +
 rtl/pythagoras_leg_isqrt.sv | 75 +++++++
 rtl/pythagoras_leg.sv | 148 ++++++++++++++
 tb/tb_pythagoras_leg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pythagoras_pkg.sv
// Shared constants and FSM encoding for the pythagoras_leg slice.
package pythagoras_pkg;
  localparam int W_DEFAULT = 8;
  localparam int LAT       = 3 * W_DEFAULT + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ_H = 3'd1,
    SQ_X = 3'd2,
    DIFF = 3'd3,
    ROOT = 3'd4
  } state_t;

  function automatic int lat_for(input int w);
    return 3 * w + 1;
  endfunction
endpackage

// File: rtl/pythagoras_leg_isqrt.sv
// Sequential restoring integer square root: one result bit per cycle, MSB first.
module seq_isqrt #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [2*W-1:0] radicand,
  output logic [W-1:0]   root,
  output logic           done
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [2*W-1:0] rad_q, rad_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   root_q, root_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;

  logic [W+2:0]   rem_sh, trial, rem_nx;
  logic [W-1:0]   root_nx;
  logic           fits;

  // The remainder never exceeds 2*root, so W+1 stored bits are sufficient.
  always_comb begin
    rem_sh  = {rem_q, rad_q[2*W-1 -: 2]};
    trial   = {1'b0, root_q, 2'b01};
    fits    = (rem_sh >= trial);
    rem_nx  = fits ? (rem_sh - trial) : rem_sh;
    root_nx = W'({root_q, fits});
  end

  // root/done present the result of the step taking place this cycle, so the
  // caller can register the final root on the same edge that retires it.
  assign root = root_nx;
  assign done = run_q && (cnt_q == LAST);

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (load) begin
      rad_d  = radicand;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      rad_d  = rad_q << 2;
      rem_d  = (W+1)'(rem_nx);
      root_d = root_nx;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end
endmodule

// File: rtl/pythagoras_leg.sv
// Computes floor(sqrt(h*h - x*x)) with a shared shift-add squarer and a bit-serial root.
// Handshake: start is accepted only in IDLE; valid pulses one cycle with leg_out/err, which then hold.
module pythagoras_leg
  import pythagoras_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] h,
  input  logic [W-1:0] x,
  input  logic         start,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] leg_out,
  output logic         err,
  output state_t       dbg_state
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   h_q, h_d, x_q, x_d;
  logic [W-1:0]   m_q, m_d;
  logic [2*W-1:0] mc_q, mc_d, acc_q, acc_d, hsq_q, hsq_d;
  logic           errf_q, errf_d;
  logic [W-1:0]   leg_q, leg_d;
  logic           err_q, err_d;
  logic           valid_q, valid_d;

  logic [2*W-1:0] acc_step;
  logic [2*W-1:0] radicand;
  logic           iso_load;
  logic [W-1:0]   iso_root;
  logic           iso_done;

  assign acc_step = m_q[0] ? (acc_q + mc_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    h_d      = h_q;
    x_d      = x_q;
    m_d      = m_q;
    mc_d     = mc_q;
    acc_d    = acc_q;
    hsq_d    = hsq_q;
    errf_d   = errf_q;
    leg_d    = leg_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    iso_load = 1'b0;
    radicand = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          h_d     = h;
          x_d     = x;
          m_d     = h;
          mc_d    = {{W{1'b0}}, h};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SQ_H;
        end
      end
      SQ_H, SQ_X: begin
        acc_d = acc_step;
        mc_d  = mc_q << 1;
        m_d   = m_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (state_q == SQ_H) begin
            // Park h*h and reload the same datapath with x.
            hsq_d   = acc_step;
            m_d     = x_q;
            mc_d    = {{W{1'b0}}, x_q};
            acc_d   = '0;
            state_d = SQ_X;
          end else begin
            state_d = DIFF;
          end
        end
      end
      DIFF: begin
        errf_d   = (x_q > h_q);
        radicand = (x_q > h_q) ? '0 : (hsq_q - acc_q);
        iso_load = 1'b1;
        state_d  = ROOT;
      end
      ROOT: begin
        if (iso_done) begin
          leg_d   = iso_root;
          err_d   = errf_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      x_q     <= '0;
      m_q     <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      hsq_q   <= '0;
      errf_q  <= 1'b0;
      leg_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      x_q     <= x_d;
      m_q     <= m_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      hsq_q   <= hsq_d;
      errf_q  <= errf_d;
      leg_q   <= leg_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  seq_isqrt #(.W(W)) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (iso_load),
    .radicand (radicand),
    .root     (iso_root),
    .done     (iso_done)
  );

  assign busy      = (state_q != IDLE);
  assign valid     = valid_q;
  assign leg_out   = leg_q;
  assign err       = err_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_pythagoras_leg.sv
// Scoreboard bench for pythagoras_leg: directed vectors, overlap/reset cases, model-checked sweep.
module tb_pythagoras_leg;
  import pythagoras_pkg::*;

  localparam int TW = W_DEFAULT;

  logic          clk;
  logic          rst_n;
  logic [TW-1:0] h, x;
  logic          start;
  logic          busy, valid, err;
  logic [TW-1:0] leg_out;
  state_t        dbg_state;

  int            cyc;
  int            checks;
  int            failures;
  logic [TW:0]   exp_q[$];
  int            exp_t_q[$];
  logic [TW:0]   last_exp;

  pythagoras_leg #(.W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h         (h),
    .x         (x),
    .start     (start),
    .busy      (busy),
    .valid     (valid),
    .leg_out   (leg_out),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [TW-1:0] ref_leg(input int hv, input int xv);
    int d;
    int r;
    d = (xv > hv) ? 0 : hv * hv - xv * xv;
    r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
    return TW'(r);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [TW:0] e;
        int          t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        last_exp = e;
        check("leg_out", 32'(leg_out), 32'(e[TW-1:0]));
        check("err", 32'(err), 32'(e[TW]));
        check("latency_cycle", 32'(cyc), 32'(t));
      end
    end
  end

  // driver: called at a negedge; start is held for exactly one cycle
  task automatic pulse(input logic [TW-1:0] hv, input logic [TW-1:0] xv,
                       input logic [TW-1:0] el, input logic ee, input bit push);
    h = hv;
    x = xv;
    start = 1'b1;
    if (push) begin
      exp_q.push_back({ee, el});
      exp_t_q.push_back(cyc + 1 + LAT);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("valid_timeout", 32'd0, 32'd1);
  endtask

  logic [TW-1:0] dh[12] = '{8'd5, 8'd13, 8'd10, 8'd255, 8'd255, 8'd10, 8'd0, 8'd100, 8'd200, 8'd1, 8'd0, 8'd17};
  logic [TW-1:0] dx[12] = '{8'd3, 8'd5,  8'd7,  8'd0,   8'd255, 8'd11, 8'd0, 8'd100, 8'd120, 8'd0, 8'd1, 8'd8};
  logic [TW-1:0] dl[12] = '{8'd4, 8'd12, 8'd7,  8'd255, 8'd0,   8'd0,  8'd0, 8'd0,   8'd160, 8'd1, 8'd0, 8'd15};
  logic          de[12] = '{1'b0, 1'b0,  1'b0,  1'b0,   1'b0,   1'b1,  1'b0, 1'b0,   1'b0,   1'b0, 1'b1, 1'b0};

  initial begin
    checks = 0;
    failures = 0;
    last_exp = '0;
    rst_n = 1'b0;
    start = 1'b0;
    h = '0;
    x = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_leg_out", 32'(leg_out), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single operation with busy window: high for LAT cycles, low on the valid cycle
    pulse(8'd5, 8'd3, 8'd4, 1'b0, 1'b1);
    check("state_after_accept", 32'(dbg_state), 32'(SQ_H));
    for (int i = 0; i < LAT; i++) begin
      check("busy_high", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("valid_on_time", 32'(valid), 32'd1);
    check("busy_low_at_valid", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("hold_leg_out", 32'(leg_out), 32'd4);

    // directed table, back-to-back: each start issued on the previous valid cycle
    pulse(dh[0], dx[0], dl[0], de[0], 1'b1);
    for (int i = 1; i < 12; i++) begin
      wait_valid();
      pulse(dh[i], dx[i], dl[i], de[i], 1'b1);
    end
    wait_valid();
    repeat (4) @(negedge clk);
    check("hold_after_err", 32'(err), 32'd0);
    check("hold_leg_last", 32'(leg_out), 32'd15);

    // starts and operand changes in flight are ignored
    pulse(8'd10, 8'd7, 8'd7, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    pulse(8'd99, 8'd1, 8'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    pulse(8'd200, 8'd199, 8'd0, 1'b0, 1'b0);
    h = 8'd3;
    x = 8'd250;
    wait_valid();
    pulse(8'd13, 8'd5, 8'd12, 1'b0, 1'b1);
    wait_valid();
    repeat (2) @(negedge clk);

    // reset during ROOT aborts the operation
    pulse(8'd255, 8'd100, 8'd234, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("state_before_reset", 32'(dbg_state), 32'(ROOT));
    rst_n = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    #1;
    check("rst_mid_leg_out", 32'(leg_out), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(valid), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    check("no_valid_after_abort", 32'(valid), 32'd0);
    pulse(8'd255, 8'd100, 8'd234, 1'b0, 1'b1);
    wait_valid();

    // model-checked sweep, back-to-back
    for (int i = 0; i < 300; i++) begin
      logic [TW-1:0] rh, rx;
      rh = TW'($urandom_range(0, 255));
      rx = (i % 4 == 0) ? TW'($urandom_range(0, 255)) : TW'($urandom_range(0, int'(rh)));
      pulse(rh, rx, ref_leg(int'(rh), int'(rx)), (rx > rh), 1'b1);
      wait_valid();
    end
    repeat (3) @(negedge clk);
    check("hold_after_sweep", 32'({err, leg_out}), 32'(last_exp));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
